// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the Game Boy CPU core: interrupt controller
// state encoding, ISR vector table and dispatch timing.
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        INT_RUN      = 2'd0,
        INT_HALTED   = 2'd1,
        INT_DISPATCH = 2'd2
    } int_state_t;

    localparam logic [7:0] INT_VEC_VBLANK = 8'h40;
    localparam logic [7:0] INT_VEC_LCD    = 8'h48;
    localparam logic [7:0] INT_VEC_TIMER  = 8'h50;
    localparam logic [7:0] INT_VEC_SERIAL = 8'h58;
    localparam logic [7:0] INT_VEC_JOYPAD = 8'h60;

    // Dispatch M-cycle in which the target vector is chosen and IF is acked.
    localparam int INT_DISPATCH_VECTOR_STEP = 3;

    // Vectors are spaced 8 bytes apart starting at VBlank.
    function automatic logic [7:0] int_vector(input int unsigned idx);
        return INT_VEC_VBLANK + 8'(idx << 3);
    endfunction

endpackage

// File: rtl/gb_cpu_int_priority.sv
// Fixed-priority interrupt encoder: lowest set bit wins, producing a one-hot
// grant, the ISR vector low byte and a valid flag.
module gb_cpu_int_priority
    import gb_cpu_common_pkg::*;
#(
    parameter int NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] pending_i,
    output logic [NUM_IRQ-1:0] grant_o,
    output logic [7:0]         vector_o,
    output logic               valid_o
);

    logic [7:0] vec_table [NUM_IRQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_vec
            assign vec_table[gi] = int_vector(gi);
        end
    endgenerate

    always_comb begin
        grant_o  = '0;
        vector_o = 8'h00;
        valid_o  = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending_i[i] && !valid_o) begin
                grant_o[i] = 1'b1;
                vector_o   = vec_table[i];
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Interrupt controller/sequencer: IME with EI delay, 5 M-cycle ISR dispatch,
// HALT and wake-up. Define GB_CPU_HALT_BUG_EN to model the DMG HALT bug.
module gb_cpu_interrupt_ctrl
    import gb_cpu_common_pkg::*;
#(
    parameter int DISPATCH_CYCLES = 5,
    parameter int NUM_IRQ         = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] int_enable,
    input  logic [NUM_IRQ-1:0] int_flag,
    input  logic               instr_boundary,
    input  logic               ei_cmd,
    input  logic               di_cmd,
    input  logic               reti_cmd,
    input  logic               halt_cmd,
    output logic               ime,
    output logic               dispatch_active,
    output logic [2:0]         dispatch_step,
    output logic [7:0]         isr_vector,
    output logic [NUM_IRQ-1:0] if_clear,
    output logic               halted,
    output logic               halt_bug
);

    localparam logic [2:0] LAST_STEP = 3'(DISPATCH_CYCLES - 1);
    localparam logic [2:0] VEC_STEP  = 3'(INT_DISPATCH_VECTOR_STEP);

    int_state_t         state_q, state_d;
    logic               ime_q, ime_d;
    logic               ei_pend_q, ei_pend_d;
    logic [2:0]         step_q, step_d;
    logic [7:0]         vec_q, vec_d;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] grant;
    logic [7:0]         grant_vec;
    logic               grant_valid;
    logic               at_vector_step;

`ifdef GB_CPU_HALT_BUG_EN
    logic               halt_bug_q, halt_bug_d;
`endif

    assign pending = int_enable & int_flag;

    gb_cpu_int_priority #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .pending_i (pending),
        .grant_o   (grant),
        .vector_o  (grant_vec),
        .valid_o   (grant_valid)
    );

    assign at_vector_step = (state_q == INT_DISPATCH) && (step_q == VEC_STEP);

    always_comb begin
        state_d   = state_q;
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        step_d    = step_q;
        vec_d     = vec_q;
`ifdef GB_CPU_HALT_BUG_EN
        halt_bug_d = 1'b0;
`endif
        unique case (state_q)
            INT_RUN: begin
                if (instr_boundary && ime_q && grant_valid) begin
                    state_d   = INT_DISPATCH;
                    step_d    = 3'd0;
                    ime_d     = 1'b0;
                    ei_pend_d = 1'b0;
                end else begin
                    if (di_cmd) begin
                        ime_d     = 1'b0;
                        ei_pend_d = 1'b0;
                    end else begin
                        if (reti_cmd) begin
                            ime_d = 1'b1;
                        end
                        // EI only takes effect at a boundary after the EI cycle.
                        if (instr_boundary && ei_pend_q) begin
                            ime_d     = 1'b1;
                            ei_pend_d = 1'b0;
                        end else if (ei_cmd) begin
                            ei_pend_d = 1'b1;
                        end
                    end
                    if (halt_cmd) begin
`ifdef GB_CPU_HALT_BUG_EN
                        if (!ime_q && grant_valid) begin
                            halt_bug_d = 1'b1;
                        end else begin
                            state_d = INT_HALTED;
                        end
`else
                        state_d = INT_HALTED;
`endif
                    end
                end
            end
            INT_HALTED: begin
                if (grant_valid) begin
                    if (ime_q) begin
                        state_d   = INT_DISPATCH;
                        step_d    = 3'd0;
                        ime_d     = 1'b0;
                        ei_pend_d = 1'b0;
                    end else begin
                        state_d = INT_RUN;
                    end
                end
            end
            INT_DISPATCH: begin
                // A request withdrawn before this step cancels to vector 0x00.
                if (at_vector_step) begin
                    vec_d = grant_valid ? grant_vec : 8'h00;
                end
                if (step_q == LAST_STEP) begin
                    state_d = INT_RUN;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            default: begin
                state_d = INT_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INT_RUN;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            step_q    <= 3'd0;
            vec_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            step_q    <= step_d;
            vec_q     <= vec_d;
        end
    end

`ifdef GB_CPU_HALT_BUG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_bug_q <= 1'b0;
        end else begin
            halt_bug_q <= halt_bug_d;
        end
    end
    assign halt_bug = halt_bug_q;
`else
    assign halt_bug = 1'b0;
`endif

    assign ime             = ime_q;
    assign dispatch_active = (state_q == INT_DISPATCH);
    assign dispatch_step   = step_q;
    assign halted          = (state_q == INT_HALTED);
    assign isr_vector      = at_vector_step ? grant_vec : vec_q;
    assign if_clear        = at_vector_step ? grant : '0;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench for gb_cpu_interrupt_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_gb_cpu_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] int_enable, int_flag;
    logic       instr_boundary, ei_cmd, di_cmd, reti_cmd, halt_cmd;
    logic       ime, dispatch_active, halted, halt_bug;
    logic [2:0] dispatch_step;
    logic [7:0] isr_vector;
    logic [4:0] if_clear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gb_cpu_interrupt_ctrl #(
        .DISPATCH_CYCLES (5),
        .NUM_IRQ         (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .int_enable      (int_enable),
        .int_flag        (int_flag),
        .instr_boundary  (instr_boundary),
        .ei_cmd          (ei_cmd),
        .di_cmd          (di_cmd),
        .reti_cmd        (reti_cmd),
        .halt_cmd        (halt_cmd),
        .ime             (ime),
        .dispatch_active (dispatch_active),
        .dispatch_step   (dispatch_step),
        .isr_vector      (isr_vector),
        .if_clear        (if_clear),
        .halted          (halted),
        .halt_bug        (halt_bug)
    );

    // Behavioural model: mode 0=running, 1=halted, 2=dispatching.
    // A dispatch is tracked by the cycle number it started in.
    int  m_mode, m_cyc, m_dstart;
    bit  m_ime, m_eip, m_bug;
    int  m_vec;

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic int vec_of(input int idx);
        return (idx < 0) ? 0 : (8'h40 + 8 * idx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int step, lo;
        bit at3;
        lo   = lowest(int_enable & int_flag);
        step = (m_mode == 2) ? (m_cyc - m_dstart) : 0;
        at3  = (m_mode == 2) && (step == 3);
        check("ime",             32'(ime),             32'(m_ime));
        check("dispatch_active", 32'(dispatch_active), 32'(m_mode == 2));
        check("dispatch_step",   32'(dispatch_step),   32'(step));
        check("isr_vector",      32'(isr_vector),      at3 ? 32'(vec_of(lo)) : 32'(m_vec));
        check("if_clear",        32'(if_clear),        (at3 && lo >= 0) ? (32'd1 << lo) : 32'd0);
        check("halted",          32'(halted),          32'(m_mode == 1));
        check("halt_bug",        32'(halt_bug),        32'(m_bug));
    endtask

    task automatic model_update();
        logic [4:0] p;
        int lo, step;
        bit old_ime, old_eip;
        p = int_enable & int_flag;
        lo = lowest(p);
        old_ime = m_ime;
        old_eip = m_eip;
        if (reset) begin
            m_mode = 0; m_ime = 0; m_eip = 0; m_bug = 0; m_vec = 0;
        end else begin
            m_bug = 0;
            if (m_mode == 0) begin
                if (instr_boundary && old_ime && p != 0) begin
                    m_mode = 2; m_dstart = m_cyc + 1; m_ime = 0; m_eip = 0;
                end else begin
                    if (di_cmd) begin
                        m_ime = 0; m_eip = 0;
                    end else begin
                        if (reti_cmd) m_ime = 1;
                        if (instr_boundary && old_eip) begin
                            m_ime = 1; m_eip = 0;
                        end else if (ei_cmd) begin
                            m_eip = 1;
                        end
                    end
                    if (halt_cmd) begin
`ifdef GB_CPU_HALT_BUG_EN
                        if (!old_ime && p != 0) m_bug = 1;
                        else m_mode = 1;
`else
                        m_mode = 1;
`endif
                    end
                end
            end else if (m_mode == 1) begin
                if (p != 0) begin
                    if (old_ime) begin
                        m_mode = 2; m_dstart = m_cyc + 1; m_ime = 0; m_eip = 0;
                    end else begin
                        m_mode = 0;
                    end
                end
            end else begin
                step = m_cyc - m_dstart;
                if (step == 3) m_vec = vec_of(lo);
                if (step == 4) m_mode = 0;
            end
        end
        m_cyc++;
    endtask

    // One M-cycle: inputs already driven at posedge+1; check at negedge.
    task automatic tick();
        #4;
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle();
        instr_boundary = 0; ei_cmd = 0; di_cmd = 0; reti_cmd = 0; halt_cmd = 0; reset = 0;
    endtask

    task automatic set_ime();
        idle(); reti_cmd = 1; tick(); reti_cmd = 0;
    endtask

    initial begin
        reset = 1; int_enable = 5'h1F; int_flag = 5'h00;
        instr_boundary = 0; ei_cmd = 0; di_cmd = 0; reti_cmd = 0; halt_cmd = 0;
        m_cyc = 0; m_dstart = 0;
        @(posedge clk);
        m_mode = 0; m_ime = 0; m_eip = 0; m_bug = 0; m_vec = 0;
        #1;
        tick();
        idle();
        tick();
        $display("txn reset");
        check("lit_reset_ime", 32'(ime), 0);
        check("lit_reset_active", 32'(dispatch_active), 0);
        check("lit_reset_halted", 32'(halted), 0);
        check("lit_reset_vec", 32'(isr_vector), 0);

        // Basic dispatch
        set_ime();
        check("lit_reti_ime", 32'(ime), 1);
        int_flag = 5'h05; instr_boundary = 1; tick(); instr_boundary = 0;
        check("lit_basic_active", 32'(dispatch_active), 1);
        check("lit_basic_ime", 32'(ime), 0);
        ticks(3);
        check("lit_basic_step", 32'(dispatch_step), 3);
        check("lit_basic_vec", 32'(isr_vector), 32'h40);
        check("lit_basic_clr", 32'(if_clear), 32'h01);
        ticks(1);
        check("lit_basic_step4", 32'(dispatch_active), 1);
        ticks(1);
        check("lit_basic_done", 32'(dispatch_active), 0);
        check("lit_basic_hold", 32'(isr_vector), 32'h40);
        int_flag = 5'h00;
        $display("txn basic_dispatch");

        // EI delay
        int_flag = 5'h04; ei_cmd = 1; instr_boundary = 1; tick(); idle();
        ticks(2);
        instr_boundary = 1; tick();
        check("lit_ei_ime", 32'(ime), 1);
        check("lit_ei_nodisp", 32'(dispatch_active), 0);
        tick(); instr_boundary = 0;
        check("lit_ei_disp", 32'(dispatch_active), 1);
        ticks(3);
        check("lit_ei_vec", 32'(isr_vector), 32'h50);
        check("lit_ei_clr", 32'(if_clear), 32'h04);
        ticks(2);
        int_flag = 5'h00;
        set_ime();
        di_cmd = 1; ei_cmd = 1; tick(); idle();
        instr_boundary = 1; ticks(2); instr_boundary = 0;
        check("lit_di_ei_ime", 32'(ime), 0);
        $display("txn ei_delay");

        // Cancelled dispatch
        set_ime();
        int_flag = 5'h02; instr_boundary = 1; tick(); instr_boundary = 0;
        int_flag = 5'h00;
        ticks(3);
        check("lit_cancel_vec", 32'(isr_vector), 0);
        check("lit_cancel_clr", 32'(if_clear), 0);
        ticks(2);
        check("lit_cancel_done", 32'(dispatch_active), 0);
        $display("txn cancelled_dispatch");

        // HALT wake, ime=0 then ime=1
        halt_cmd = 1; tick(); halt_cmd = 0;
        check("lit_halt_enter", 32'(halted), 1);
        tick();
        int_flag = 5'h10; tick();
        check("lit_wake_halted", 32'(halted), 0);
        check("lit_wake_nodisp", 32'(dispatch_active), 0);
        int_flag = 5'h00;
        set_ime();
        halt_cmd = 1; tick(); halt_cmd = 0;
        int_flag = 5'h10; tick();
        check("lit_wake_disp", 32'(dispatch_active), 1);
        ticks(3);
        check("lit_wake_vec", 32'(isr_vector), 32'h60);
        check("lit_wake_clr", 32'(if_clear), 32'h10);
        ticks(2);
        int_flag = 5'h00;
        $display("txn halt_wake");

        // HALT with ime=0 and a pending request
        int_flag = 5'h01; halt_cmd = 1; tick(); halt_cmd = 0;
`ifdef GB_CPU_HALT_BUG_EN
        check("lit_bug_pulse", 32'(halt_bug), 1);
        check("lit_bug_nohalt", 32'(halted), 0);
        tick();
        check("lit_bug_end", 32'(halt_bug), 0);
`else
        check("lit_bug_halted", 32'(halted), 1);
        check("lit_bug_zero", 32'(halt_bug), 0);
        tick();
        check("lit_bug_exit", 32'(halted), 0);
`endif
        int_flag = 5'h00;
        $display("txn halt_bug");

        // Reset during dispatch step 2
        set_ime();
        int_flag = 5'h01; instr_boundary = 1; tick(); instr_boundary = 0;
        ticks(2);
        check("lit_rst_step2", 32'(dispatch_step), 2);
        reset = 1; tick(); reset = 0;
        check("lit_rst_active", 32'(dispatch_active), 0);
        check("lit_rst_step", 32'(dispatch_step), 0);
        check("lit_rst_ime", 32'(ime), 0);
        check("lit_rst_vec", 32'(isr_vector), 0);
        tick();
        check("lit_rst_noclr", 32'(if_clear), 0);
        int_flag = 5'h00;
        $display("txn reset_mid_dispatch");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int_enable     = 5'($urandom);
            int_flag       = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00;
            instr_boundary = ($urandom_range(0, 2) == 0);
            ei_cmd         = ($urandom_range(0, 11) == 0);
            di_cmd         = ($urandom_range(0, 29) == 0);
            reti_cmd       = ($urandom_range(0, 13) == 0);
            halt_cmd       = ($urandom_range(0, 19) == 0);
            reset          = ($urandom_range(0, 255) == 0);
            tick();
        end
        idle();
        tick();
        $display("txn random_traffic cycles=3000");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
